xup_xor_descrambler: RTL

Streaming additive (frame-synchronous) descrambler for the XUP library: the receive-side counterpart of the library's XOR-based scrambler. It XORs each incoming SIZE-bit word with a keystream from a 7-bit Fibonacci LFSR (x^7 + x^6 + 1), reseeded at every start-of-frame, and returns the original data. It sits between a link receiver and the consumer. Valid/ready handshakes are on both sides, with one registered output stage.

---
 rtl/xup_scrambler_pkg.sv | 14 +
 rtl/xup_lfsr_step.sv | 26 ++
 rtl/xup_xor_descrambler.sv | 107 ++++++++++
 3 files changed

// File: rtl/xup_scrambler_pkg.sv
// Shared constants and types for the XUP additive scrambler/descrambler pair.
package xup_scrambler_pkg;

  localparam int unsigned LFSR_W = 7;
  localparam int unsigned TAP_HI = 6;
  localparam int unsigned TAP_LO = 5;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 7'h7F;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/xup_lfsr_step.sv
// Combinational multi-step Fibonacci LFSR (x^7 + x^6 + 1): keystream bits plus next state.
module xup_lfsr_step
  import xup_scrambler_pkg::*;
#(
  parameter int unsigned STEPS = 4
) (
  input  logic [LFSR_W-1:0] state_i,
  output logic [STEPS-1:0]  key_o,
  output logic [LFSR_W-1:0] next_o
);

  // Unroll STEPS shifts; key bit i is the feedback produced on step i.
  always_comb begin
    logic [LFSR_W-1:0] st;
    logic              fb;
    st    = state_i;
    key_o = '0;
    for (int unsigned i = 0; i < STEPS; i++) begin
      fb       = st[TAP_HI] ^ st[TAP_LO];
      key_o[i] = fb;
      st       = {st[LFSR_W-2:0], fb};
    end
    next_o = st;
  end

endmodule

// File: rtl/xup_xor_descrambler.sv
// Frame-synchronous additive descrambler with valid/ready handshake and one output register.
module xup_xor_descrambler
  import xup_scrambler_pkg::*;
#(
  parameter int unsigned       SIZE = 4,
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [SIZE-1:0] s_data,
  input  logic            s_sof,
  input  logic            s_valid,
  output logic            s_ready,
  output logic [SIZE-1:0] m_data,
  output logic            m_sof,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            locked,
  output logic [7:0]      drop_cnt
);

  state_e            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [SIZE-1:0]   m_data_q, m_data_d;
  logic              m_sof_q, m_sof_d;
  logic              m_valid_q, m_valid_d;
  logic              locked_q, locked_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  logic              accept;
  logic              drop;
  logic              process;
  logic [LFSR_W-1:0] lfsr_start;
  logic [LFSR_W-1:0] lfsr_next;
  logic [SIZE-1:0]   key;

  assign s_ready = !m_valid_q || m_ready;

  xup_lfsr_step #(
    .STEPS(SIZE)
  ) u_step (
    .state_i(lfsr_start),
    .key_o  (key),
    .next_o (lfsr_next)
  );

  // Handshake decode, keystream seeding, FSM and output-register next-state logic.
  always_comb begin
    accept     = s_valid && s_ready;
    drop       = accept && (state_q == IDLE) && !s_sof;
    process    = accept && !drop;
    lfsr_start = s_sof ? SEED : lfsr_q;

    state_d    = state_q;
    lfsr_d     = lfsr_q;
    m_data_d   = m_data_q;
    m_sof_d    = m_sof_q;
    m_valid_d  = m_valid_q;
    drop_cnt_d = drop_cnt_q;

    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end

    if (process) begin
      lfsr_d    = lfsr_next;
      m_data_d  = s_data ^ key;
      m_sof_d   = s_sof;
      m_valid_d = 1'b1;
      state_d   = RUN;
    end

    if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end

    locked_d = (state_d == RUN);
  end

  // All state registers, cleared asynchronously.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      lfsr_q     <= SEED;
      m_data_q   <= '0;
      m_sof_q    <= 1'b0;
      m_valid_q  <= 1'b0;
      locked_q   <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      m_data_q   <= m_data_d;
      m_sof_q    <= m_sof_d;
      m_valid_q  <= m_valid_d;
      locked_q   <= locked_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign m_data   = m_data_q;
  assign m_sof    = m_sof_q;
  assign m_valid  = m_valid_q;
  assign locked   = locked_q;
  assign drop_cnt = drop_cnt_q;

endmodule
